hazard_scoreboard_unit: RTL and testbench

Parametrised ID-stage hazard unit for the pipelined RISC-V core with variable-latency loads and a multi-cycle mul/div unit. Keeps a per-register pending-write scoreboard that is set when a long-latency instruction issues from ID to EX. Each entry is cleared when the memory response arrives or when the mul/div countdown expires. Drives stall (hold PC and IF/ID) and nop (bubble into ID/EX), replacing the single-cycle load-use check.

---
 rtl/hazard_scoreboard_unit.sv | 153 +++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
// ID-stage hazard unit with a per-register pending-write scoreboard for
// variable-latency loads and a fixed-latency mul/div unit. Drives stall/nop,
// counts outstanding loads and flags protocol errors (sticky sb_err).
// Optional build macro: HAZARD_RESP_BYPASS_EN -- when defined, RAW/WAW checks
// ignore a register that is being cleared this very cycle (writeback bypass).
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_LOADS  = 2,
  parameter int MD_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  id_is_muldiv,
  input  logic                  flush,
  input  logic                  mem_resp_valid,
  input  logic [REG_ADDR_W-1:0] mem_resp_rd,
  output logic                  stall,
  output logic                  nop,
  output logic                  md_busy,
  output logic [2:0]            load_count,
  output logic                  sb_err
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  // Counter holds MD_LATENCY-1 down to 1; completion is the cycle it steps to 0.
  localparam int CNT_W    = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

  // One-hot decode of a register index into a scoreboard-wide vector.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_ADDR_W-1:0] idx);
    onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  logic [NUM_REGS-1:0]   pend_q, pend_d;
  logic [2:0]            load_count_q, load_count_d;
  logic [CNT_W-1:0]      md_cnt_q, md_cnt_d;
  logic                  md_busy_q, md_busy_d;
  logic [REG_ADDR_W-1:0] md_rd_q, md_rd_d;
  logic                  sb_err_q, sb_err_d;

  logic                  resp_ok_s;
  logic                  md_done_s;
  logic [NUM_REGS-1:0]   clr_vec_s;
  logic [NUM_REGS-1:0]   set_vec_s;
  logic [NUM_REGS-1:0]   pend_eff_s;
  logic                  raw_s, waw_s, struct_s, stall_s;
  logic                  issue_s, ld_issue_s, md_issue_s, rd_set_s;
  logic                  resp_bad_s, ovf_s;
  logic                  loads_full_s;

  // A response is only honoured while a load is outstanding.
  assign resp_ok_s    = mem_resp_valid & (load_count_q != 3'd0);
  // Mul/div finishes in the cycle its countdown steps from 1 to 0.
  assign md_done_s    = md_busy_q & (md_cnt_q == CNT_W'(1));
  assign loads_full_s = (load_count_q == 3'(MAX_LOADS));

  assign clr_vec_s = (resp_ok_s ? onehot(mem_resp_rd) : {NUM_REGS{1'b0}})
                   | (md_done_s ? onehot(md_rd_q)     : {NUM_REGS{1'b0}});

`ifdef HAZARD_RESP_BYPASS_EN
  // Results written back this cycle are forwarded, so their entries look free.
  assign pend_eff_s = pend_q & ~clr_vec_s;
`else
  // No bypass: wait until the registered entry has actually cleared.
  assign pend_eff_s = pend_q;
`endif

  // Hazard detection and issue qualification for the instruction in ID.
  always_comb begin
    raw_s      = (id_uses_rs1 & pend_eff_s[id_rs1]) | (id_uses_rs2 & pend_eff_s[id_rs2]);
    waw_s      = id_reg_write & pend_eff_s[id_rd];
    struct_s   = (id_is_muldiv & md_busy_q) | (id_is_load & loads_full_s);
    stall_s    = id_valid & ~flush & (raw_s | waw_s | struct_s);
    issue_s    = id_valid & ~stall_s & ~flush;
    ld_issue_s = issue_s & id_is_load;
    md_issue_s = issue_s & id_is_muldiv;
    rd_set_s   = id_reg_write & (id_rd != {REG_ADDR_W{1'b0}});
    set_vec_s  = ((ld_issue_s | md_issue_s) & rd_set_s) ? onehot(id_rd) : {NUM_REGS{1'b0}};
    // Unmatched response: nothing outstanding, or a non-x0 target not pending.
    resp_bad_s = mem_resp_valid & ((load_count_q == 3'd0) |
                 ((mem_resp_rd != {REG_ADDR_W{1'b0}}) & ~pend_q[mem_resp_rd]));
    ovf_s      = ld_issue_s & loads_full_s;
  end

  // Next-state for scoreboard, load counter, mul/div countdown and error flag.
  always_comb begin
    pend_d       = (pend_q & ~clr_vec_s) | set_vec_s;
    pend_d[0]    = 1'b0;
    load_count_d = load_count_q;
    md_cnt_d     = md_cnt_q;
    md_busy_d    = md_busy_q;
    md_rd_d      = md_rd_q;
    sb_err_d     = sb_err_q | resp_bad_s | ovf_s;

    case ({ld_issue_s, resp_ok_s})
      2'b10:   load_count_d = (load_count_q == 3'd7) ? load_count_q : load_count_q + 3'd1;
      2'b01:   load_count_d = load_count_q - 3'd1;
      default: load_count_d = load_count_q;
    endcase

    if (md_issue_s) begin
      md_cnt_d  = CNT_W'(MD_LATENCY - 1);
      md_busy_d = 1'b1;
      md_rd_d   = id_rd;
    end else if (md_done_s) begin
      md_cnt_d  = {CNT_W{1'b0}};
      md_busy_d = 1'b0;
      md_rd_d   = md_rd_q;
    end else if (md_busy_q) begin
      md_cnt_d  = md_cnt_q - CNT_W'(1);
      md_busy_d = 1'b1;
      md_rd_d   = md_rd_q;
    end else begin
      md_cnt_d  = md_cnt_q;
      md_busy_d = md_busy_q;
      md_rd_d   = md_rd_q;
    end
  end

  // State registers; reset discards every pending entry and the error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= {NUM_REGS{1'b0}};
      load_count_q <= 3'd0;
      md_cnt_q     <= {CNT_W{1'b0}};
      md_busy_q    <= 1'b0;
      md_rd_q      <= {REG_ADDR_W{1'b0}};
      sb_err_q     <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      load_count_q <= load_count_d;
      md_cnt_q     <= md_cnt_d;
      md_busy_q    <= md_busy_d;
      md_rd_q      <= md_rd_d;
      sb_err_q     <= sb_err_d;
    end
  end

  assign stall      = stall_s;
  assign nop        = stall_s;
  assign md_busy    = md_busy_q;
  assign load_count = load_count_q;
  assign sb_err     = sb_err_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed testbench for hazard_scoreboard_unit (default parameters:
// REG_ADDR_W=5, MAX_LOADS=2, MD_LATENCY=4). Expected values are hand-derived;
// the same-cycle-clear cases follow HAZARD_RESP_BYPASS_EN if it is defined.
module tb_hazard_scoreboard_unit;

`ifdef HAZARD_RESP_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd, mem_resp_rd;
  logic       id_uses_rs1, id_uses_rs2, id_reg_write, id_is_load, id_is_muldiv;
  logic       flush, mem_resp_valid;
  logic       stall, nop, md_busy, sb_err;
  logic [2:0] load_count;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv),
    .flush(flush), .mem_resp_valid(mem_resp_valid), .mem_resp_rd(mem_resp_rd),
    .stall(stall), .nop(nop), .md_busy(md_busy), .load_count(load_count), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic rw, input logic ld, input logic md);
    id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_is_load = ld; id_is_muldiv = md;
  endtask

  task automatic resp(input logic v, input logic [4:0] rd);
    mem_resp_valid = v; mem_resp_rd = rd;
  endtask

  task automatic idle();
    ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    resp(1'b0, 5'd0);
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    // ---------------- reset with stimulus toggling ----------------
    cyc();
    ins(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    resp(1'b1, 5'd5);
    #1;
    chk("rst_stall", {7'd0, stall}, 8'd0);
    chk("rst_nop", {7'd0, nop}, 8'd0);
    chk("rst_lc", {5'd0, load_count}, 8'd0);
    cyc();
    ins(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
    #1;
    chk("rst_err", {7'd0, sb_err}, 8'd0);
    chk("rst_md", {7'd0, md_busy}, 8'd0);
    cyc();
    idle();
    rst_n = 1'b1;
    #1;
    chk("post_rst_lc", {5'd0, load_count}, 8'd0);
    chk("post_rst_err", {7'd0, sb_err}, 8'd0);
    chk("post_rst_stall", {7'd0, stall}, 8'd0);
    cyc();

    // ---------------- load-use: lw x5 ; add x6,x5,x1 ----------------
    ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    #1; chk("lu_load_issue", {7'd0, stall}, 8'd0);
    cyc();
    ins(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1; chk("lu_stall1", {7'd0, stall}, 8'd1);
    chk("lu_nop1", {7'd0, nop}, 8'd1);
    chk("lu_lc1", {5'd0, load_count}, 8'd1);
    cyc();
    #1; chk("lu_stall2", {7'd0, stall}, 8'd1);
    cyc();
    #1; chk("lu_stall3", {7'd0, stall}, 8'd1);
    cyc();
    resp(1'b1, 5'd5);
    #1; chk("lu_stall_resp", {7'd0, stall}, {7'd0, ~BYP});
    chk("lu_lc_resp", {5'd0, load_count}, 8'd1);
    cyc();
    resp(1'b0, 5'd0);
    #1; chk("lu_free", {7'd0, stall}, 8'd0);
    chk("lu_lc0", {5'd0, load_count}, 8'd0);
    cyc();

    // ---------------- MAX_LOADS: loads to x1, x2, x3 ----------------
    ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);
    #1; chk("ml_l1", {7'd0, stall}, 8'd0);
    cyc();
    ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    #1; chk("ml_l2", {7'd0, stall}, 8'd0);
    chk("ml_lc1", {5'd0, load_count}, 8'd1);
    cyc();
    ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    #1; chk("ml_l3_stall", {7'd0, stall}, 8'd1);
    chk("ml_lc2", {5'd0, load_count}, 8'd2);
    cyc();
    resp(1'b1, 5'd1);
    #1; chk("ml_l3_stall_resp", {7'd0, stall}, 8'd1);
    chk("ml_lc2b", {5'd0, load_count}, 8'd2);
    cyc();
    resp(1'b0, 5'd0);
    #1; chk("ml_l3_issue", {7'd0, stall}, 8'd0);
    chk("ml_lc1b", {5'd0, load_count}, 8'd1);
    cyc();
    ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    resp(1'b1, 5'd2);
    #1; chk("ml_lc2c", {5'd0, load_count}, 8'd2);
    cyc();
    // load issue and response together: count unchanged
    ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    resp(1'b1, 5'd3);
    #1; chk("ml_both_stall", {7'd0, stall}, 8'd0);
    chk("ml_both_lc_pre", {5'd0, load_count}, 8'd1);
    cyc();
    idle();
    resp(1'b1, 5'd9);
    #1; chk("ml_both_lc_post", {5'd0, load_count}, 8'd1);
    cyc();
    resp(1'b0, 5'd0);
    #1; chk("ml_drain_lc", {5'd0, load_count}, 8'd0);
    chk("ml_drain_err", {7'd0, sb_err}, 8'd0);

    // ---------------- mul x7 ; div x8 ; add reads x8 ----------------
    ins(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
    #1; chk("md_mul_issue", {7'd0, stall}, 8'd0);
    chk("md_idle_busy", {7'd0, md_busy}, 8'd0);
    cyc();
    ins(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
    #1; chk("md_div_s1", {7'd0, stall}, 8'd1);
    chk("md_busy1", {7'd0, md_busy}, 8'd1);
    cyc();
    #1; chk("md_div_s2", {7'd0, stall}, 8'd1);
    cyc();
    #1; chk("md_div_s3", {7'd0, stall}, 8'd1);
    cyc();
    #1; chk("md_div_issue", {7'd0, stall}, 8'd0);
    chk("md_busy0", {7'd0, md_busy}, 8'd0);
    cyc();
    ins(1'b1, 5'd8, 1'b1, 5'd7, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    #1; chk("md_raw1", {7'd0, stall}, 8'd1);
    cyc();
    #1; chk("md_raw2", {7'd0, stall}, 8'd1);
    cyc();
    #1; chk("md_raw_done", {7'd0, stall}, {7'd0, ~BYP});
    cyc();
    #1; chk("md_raw_free", {7'd0, stall}, 8'd0);
    chk("md_busy_end", {7'd0, md_busy}, 8'd0);
    cyc();

    // ---------------- flush with stalled load-use pair ----------------
    ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    cyc();
    ins(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1; chk("fl_stall", {7'd0, stall}, 8'd0);
    chk("fl_nop", {7'd0, nop}, 8'd0);
    cyc();
    flush = 1'b0;
    #1; chk("fl_after_stall", {7'd0, stall}, 8'd1);
    chk("fl_after_lc", {5'd0, load_count}, 8'd1);
    cyc();
    ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    ins(1'b1, 5'd6, 1'b1, 5'd5, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
    #1; chk("fl_load_killed", {7'd0, stall}, 8'd0);
    chk("fl_load_lc", {5'd0, load_count}, 8'd1);
    cyc();
    idle();
    resp(1'b1, 5'd5);
    cyc();
    resp(1'b0, 5'd0);
    #1; chk("fl_drain_lc", {5'd0, load_count}, 8'd0);
    chk("fl_drain_err", {7'd0, sb_err}, 8'd0);

    // ---------------- sb_err and loads to x0 ----------------
    resp(1'b1, 5'd3);
    #1; chk("err_pre", {7'd0, sb_err}, 8'd0);
    cyc();
    resp(1'b0, 5'd0);
    #1; chk("err_set", {7'd0, sb_err}, 8'd1);
    chk("err_lc", {5'd0, load_count}, 8'd0);
    cyc();
    ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    #1; chk("x0_load_issue", {7'd0, stall}, 8'd0);
    chk("err_held", {7'd0, sb_err}, 8'd1);
    cyc();
    ins(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    #1; chk("x0_no_raw", {7'd0, stall}, 8'd0);
    chk("x0_lc", {5'd0, load_count}, 8'd1);
    cyc();
    idle();
    resp(1'b1, 5'd0);
    cyc();
    resp(1'b0, 5'd0);
    #1; chk("x0_lc0", {5'd0, load_count}, 8'd0);
    chk("err_sticky", {7'd0, sb_err}, 8'd1);

    // ---------------- reset mid-operation discards state ----------------
    ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    cyc();
    idle();
    #1; chk("mid_lc_pre", {5'd0, load_count}, 8'd1);
    rst_n = 1'b0;
    #1; chk("mid_lc_rst", {5'd0, load_count}, 8'd0);
    chk("mid_err_rst", {7'd0, sb_err}, 8'd0);
    cyc();
    rst_n = 1'b1;
    ins(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    #1; chk("mid_no_stall", {7'd0, stall}, 8'd0);
    cyc();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
